pipelined_segmented_adder: RTL and testbench

- Parametrised, pipelined successor to the team's single-cycle ripple-carry adder.
- Splits a DATA_WIDTH-bit add/subtract into NUM_STAGES equal segments and adds one segment per pipeline stage.
- Registers the inter-segment carry between stages and skews the operands to match, for high Fmax.
- Streams operations with a valid/ready handshake and full-pipeline backpressure, and reports carry-out and signed overflow.

---
 rtl/pipelined_segmented_adder_if.sv | 32 +++
 rtl/pipelined_segmented_adder.sv | 103 ++++++++++
 tb/tb_pipelined_segmented_adder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_segmented_adder_if.sv
`default_nettype none
// ============================================================================
// Module : pipelined_segmented_adder_if
// Brief  : Valid/ready operand and result bus for the segmented adder.
// Rev    : 1.0  initial release
// ============================================================================
interface pipelined_segmented_adder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  cin;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] sum;
    logic                  cout;
    logic                  overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_segmented_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_segmented_adder
// Brief  : Add/subtract split into NUM_STAGES segments, one segment per stage.
// Rev    : 1.0  initial release
// ============================================================================
module pipelined_segmented_adder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    pipelined_segmented_adder_if.slave bus
);
    localparam int c_seg_w = DATA_WIDTH / NUM_STAGES;

    logic w_advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operands shrink by one segment per stage; results grow by one.
        localparam int c_op_w  = (NUM_STAGES - k) * c_seg_w;
        localparam int c_res_w = (k + 1) * c_seg_w;

        logic [c_op_w-1:0]  w_a;
        logic [c_op_w-1:0]  w_b;
        logic               w_cin;
        logic               w_vin;
        logic [c_seg_w:0]   w_seg;
        logic [c_res_w-1:0] w_res;

        if (k == 0) begin : g_first
            assign w_a   = bus.a;
            assign w_b   = bus.sub ? ~bus.b : bus.b;
            assign w_cin = bus.sub | bus.cin;
            assign w_vin = bus.in_valid;
            assign w_res = w_seg[c_seg_w-1:0];
        end else begin : g_next
            assign w_a   = g_stage[k-1].g_mid.r_a;
            assign w_b   = g_stage[k-1].g_mid.r_b;
            assign w_cin = g_stage[k-1].g_mid.r_carry;
            assign w_vin = g_stage[k-1].g_mid.r_valid;
            assign w_res = {w_seg[c_seg_w-1:0], g_stage[k-1].g_mid.r_res};
        end

        assign w_seg = {1'b0, w_a[c_seg_w-1:0]} + {1'b0, w_b[c_seg_w-1:0]}
                     + {{c_seg_w{1'b0}}, w_cin};

        if (k < NUM_STAGES - 1) begin : g_mid
            logic                        r_valid;
            logic                        r_carry;
            logic [c_op_w-c_seg_w-1:0]   r_a;
            logic [c_op_w-c_seg_w-1:0]   r_b;
            logic [c_res_w-1:0]          r_res;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_res   <= '0;
                end else if (w_advance) begin
                    r_valid <= w_vin;
                    r_carry <= w_seg[c_seg_w];
                    r_a     <= w_a[c_op_w-1:c_seg_w];
                    r_b     <= w_b[c_op_w-1:c_seg_w];
                    r_res   <= w_res;
                end
            end
        end else begin : g_last
            logic               r_valid;
            logic               r_cout;
            logic               r_ovf;
            logic [c_res_w-1:0] r_sum;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_cout  <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_sum   <= '0;
                end else if (w_advance) begin
                    r_valid <= w_vin;
                    r_cout  <= w_seg[c_seg_w];
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    r_ovf   <= w_a[c_op_w-1] ^ w_b[c_op_w-1] ^ w_seg[c_seg_w-1]
                             ^ w_seg[c_seg_w];
                    r_sum   <= w_res;
                end
            end
        end
    end

    // A full-pipeline stall holds every stage whenever the result is blocked.
    assign w_advance     = !g_stage[NUM_STAGES-1].g_last.r_valid || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = g_stage[NUM_STAGES-1].g_last.r_valid;
    assign bus.sum       = g_stage[NUM_STAGES-1].g_last.r_sum;
    assign bus.cout      = g_stage[NUM_STAGES-1].g_last.r_cout;
    assign bus.overflow  = g_stage[NUM_STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_segmented_adder.sv
`default_nettype none
// Bench for pipelined_segmented_adder: directed literal cases plus randomized
// streaming against a slot-array reference model checked every cycle.
module tb_pipelined_segmented_adder;
    localparam int DW = 32;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;

    pipelined_segmented_adder_if #(.DATA_WIDTH(DW)) bus ();
    pipelined_segmented_adder_if #(.DATA_WIDTH(8))  bus8 ();

    pipelined_segmented_adder #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    pipelined_segmented_adder #(.DATA_WIDTH(8), .NUM_STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
    );

    typedef struct packed {
        logic          v;
        logic [DW-1:0] s;
        logic          c;
        logic          o;
    } slot_t;

    slot_t pipe [NS];
    slot_t nxt;
    logic  m_adv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic and the sign rule for overflow.
    function automatic slot_t model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                    input logic mcin, input logic msub);
        logic [DW-1:0] bb;
        logic [DW:0]   full;
        slot_t         r;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{DW{1'b0}}, (msub ? 1'b1 : mcin)};
        r.v  = 1'b1;
        r.s  = full[DW-1:0];
        r.c  = full[DW];
        r.o  = (ma[DW-1] == bb[DW-1]) && (full[DW-1] != ma[DW-1]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Cycle-by-cycle compare: the pipeline is a row of NS slots that shifts
    // on every cycle the output is not blocked.
    initial begin
        for (int i = 0; i < NS; i++) pipe[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NS; i++) begin
                    if (pipe[i].v) n_acc--;
                    pipe[i] = '0;
                end
                check("rst_out_valid", bus.out_valid, 0);
            end else begin
                m_adv = !pipe[NS-1].v || bus.out_ready;
                check("in_ready", bus.in_ready, m_adv);
                check("out_valid", bus.out_valid, pipe[NS-1].v);
                if (pipe[NS-1].v) begin
                    check("sum", bus.sum, pipe[NS-1].s);
                    check("cout", bus.cout, pipe[NS-1].c);
                    check("overflow", bus.overflow, pipe[NS-1].o);
                    if (bus.out_ready) n_out++;
                end
                if (m_adv) begin
                    if (bus.in_valid) n_acc++;
                    for (int i = NS - 1; i > 0; i--) pipe[i] = pipe[i-1];
                    nxt   = model(bus.a, bus.b, bus.cin, bus.sub);
                    nxt.v = bus.in_valid;
                    pipe[0] = nxt;
                end
            end
        end
    end

    task automatic directed(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                            input logic tcin, input logic tsub, input logic [DW-1:0] es,
                            input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = ta; bus.b = tb; bus.cin = tcin; bus.sub = tsub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, lat, NS);
        check({name, "_sum"}, bus.sum, es);
        check({name, "_cout"}, bus.cout, ec);
        check({name, "_ovf"}, bus.overflow, eo);
    endtask

    task automatic directed8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                             input logic tcin, input logic tsub, input logic [7:0] es,
                             input logic ec, input logic eo);
        @(posedge clk); #1;
        bus8.in_valid = 1'b1;
        bus8.a = ta; bus8.b = tb; bus8.cin = tcin; bus8.sub = tsub;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, bus8.out_valid, 1);
        check({name, "_sum"}, bus8.sum, es);
        check({name, "_cout"}, bus8.cout, ec);
        check({name, "_ovf"}, bus8.overflow, eo);
        @(negedge clk);
        check({name, "_single"}, bus8.out_valid, 0);
    endtask

    task automatic run(input int nbeats, input int vpct, input int rpct,
                       input int st_lo, input int st_hi);
        int            sent = 0;
        int            cyc = 0;
        bit            xfer = 1'b0;
        bit            was_stall = 1'b0;
        logic [DW-1:0] held;
        while ((sent < nbeats || (bus.in_valid && !xfer)) && cyc < 5000) begin
            @(posedge clk); #1;
            if (!bus.in_valid || xfer) begin
                bus.a = rnd_op(); bus.b = rnd_op();
                bus.cin = 1'($urandom); bus.sub = 1'($urandom);
                if (sent < nbeats && $urandom_range(99) < vpct) begin
                    bus.in_valid = 1'b1;
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = (cyc >= st_lo && cyc < st_hi) ? 1'b0
                          : ($urandom_range(99) < rpct);
            @(negedge clk);
            xfer = bus.in_valid && bus.in_ready;
            if (was_stall) begin
                check("stall_hold_sum", bus.sum, held);
                check("stall_hold_valid", bus.out_valid, 1);
            end
            was_stall = bus.out_valid && !bus.out_ready;
            held      = bus.sum;
            cyc++;
        end
        check("run_budget", cyc < 5000, 1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NS + 2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus8.out_ready = 1'b1;
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_cout", bus.cout, 0);
        check("reset_ovf", bus.overflow, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset8_out_valid", bus8.out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_cin", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        directed8("n1_add", 8'hC8, 8'h64, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0);
        directed8("n1_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed8("n1_sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);

        run(8, 100, 100, -1, -1);
        run(12, 100, 100, 7, 10);
        run(300, 70, 60, -1, -1);
        check("no_loss_or_dup", n_out, n_acc);

        // Reset with beats in flight and a result presented.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = rnd_op(); bus.b = rnd_op(); bus.sub = 1'($urandom); bus.cin = 1'($urandom);
        repeat (4) begin
            @(posedge clk); #1;
            bus.a = rnd_op(); bus.b = rnd_op(); bus.sub = 1'($urandom); bus.cin = 1'($urandom);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pre_reset_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        check("midrst_ovf", bus.overflow, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_no_result", bus.out_valid, 0);
        end
        check("no_loss_after_reset", n_out, n_acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
